if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries; DEPTH SHALL be a power of two, minimum 2.
REQ-002 SHALL have parameter PC_BASE, default 32'h0000_3000, the instruction-memory base address.
REQ-003 SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  redirect from the branch/jump unit; discards all queued entries.
REQ-006 SHALL have port in_valid  input  1  the fetch stage presents a fetched pair.
REQ-007 SHALL have port in_ready  output  1  the queue accepts a pair this cycle.
REQ-008 SHALL have port in_pc  input  32  PC of the fetched instruction.
REQ-009 SHALL have port in_instr  input  32  fetched instruction word.
REQ-010 SHALL have port out_valid  output  1  the head entry is valid for decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes the head this cycle; deasserted on decode stall.
REQ-012 SHALL have port out_pc  output  32  PC of the head entry.
REQ-013 SHALL have port out_instr  output  32  instruction of the head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL push {in_pc, in_instr} at the tail on a clock edge where in_valid and in_ready are both 1.
REQ-016 SHALL pop the head on a clock edge where out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = (count != DEPTH), with no combinational dependence on out_ready; a full queue SHALL reject input even when a pop occurs in the same cycle.
REQ-018 SHALL drive out_valid = (count != 0), from registered state only.
REQ-019 SHALL give 1-cycle latency: a pair pushed at edge N appears at the head no earlier than after edge N; there SHALL be no combinational bypass from in_* to out_*.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop, and SHALL advance both pointers.
REQ-021 SHALL ignore a pop request when the queue is empty and a push request when it is full, with no change of state.
REQ-022 SHALL keep the head and tail pointers as $clog2(DEPTH)-bit values that wrap modulo DEPTH.
REQ-023 SHALL, while out_valid is 0, drive out_pc = 0 and out_instr = 0 so that decode sees a nop bubble.
REQ-024 SHALL, on flush = 1 at an edge, set count to 0, set head = tail = 0, and discard any push or pop in that same cycle.
REQ-025 SHALL give reset priority over flush, and flush priority over push and pop.
REQ-026 SHALL hold the head entry stable while out_valid is 1 and out_ready is 0.

Reset
REQ-027 SHALL, on reset at an edge, set count = 0, head = tail = 0, out_valid = 0, in_ready = 1, out_pc = 0 and out_instr = 0.
REQ-028 SHALL, when reset is asserted mid-operation, discard all entries, and the first push after reset deasserts SHALL be the next head.
REQ-029 SHALL not require entry storage contents to be cleared on reset; invalid entries SHALL never be visible on the outputs.

Configuration
REQ-030 SHALL, with macro IFQ_ADDR_EXC_EN defined, add output out_exc (1 bit) and a stored exception bit per entry; the bit SHALL be set at push when in_pc[1:0] != 0 or in_pc is outside [PC_BASE, PC_BASE+16K-4].
REQ-031 SHALL, with IFQ_ADDR_EXC_EN defined, store in_instr as 0 for a faulting entry.
REQ-032 SHALL, with IFQ_ADDR_EXC_EN defined, drive out_exc = 0 when out_valid is 0.
REQ-033 SHALL, without IFQ_ADDR_EXC_EN, have no out_exc port and no exception storage.

Structure
REQ-034 SHALL take PC_BASE, the instruction-memory size (4096 words), the nop encoding 32'h0000_0000 and the AdEL exception code 4'd4 from the shared package ifq_pkg.
REQ-035 SHALL place entry storage in one sub-module, ifq_entry_ram, with one write port and one asynchronous read port addressed by head.

Verification
REQ-036 SHALL cover fill to full: after reset, push PCs 0x3000, 0x3004, 0x3008, 0x300C with out_ready = 0 -> count = 4, in_ready = 0, and a fifth push of 0x3010 is dropped.
REQ-037 SHALL cover drain in order: from full, hold out_ready = 1 -> out_pc is 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles, then out_valid = 0 with out_pc = 0 and out_instr = 0.
REQ-038 SHALL cover simultaneous push and pop: at count = 2, push 0x3010 while popping -> count stays 2, and the head advances to the next PC.
REQ-039 SHALL cover pointer wrap-around: push and pop 10 sequential PCs at count = 1 -> outputs in order across wrap, count never exceeds 2.
REQ-040 SHALL cover flush: at count = 3, assert flush together with a push of 0x4000 -> next cycle count = 0 and out_valid = 0; a push of 0x5000 in the following cycle is the head one cycle later.
REQ-041 SHALL cover the address exception with IFQ_ADDR_EXC_EN defined: push in_pc = 0x3002 and then 0x7000 -> each entry shows out_exc = 1 and out_instr = 0; push 0x3004 -> out_exc = 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared constants, entry layout and address-check helper for the
// IF/ID queue. Optional feature macro: IFQ_ADDR_EXC_EN (per-entry AdEL bit).
package ifq_pkg;

  localparam logic [31:0] IFQ_PC_BASE    = 32'h0000_3000;
  localparam int unsigned IFQ_IMEM_WORDS = 4096;
  localparam logic [31:0] IFQ_NOP        = 32'h0000_0000;
  // Cause code the downstream exception logic reports for a flagged entry.
  localparam logic [3:0]  IFQ_EXC_ADEL   = 4'd4;

  typedef struct packed {
`ifdef IFQ_ADDR_EXC_EN
    logic        exc;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  // Misaligned, or outside [base, base + 4*IMEM_WORDS - 4].
  function automatic logic ifq_addr_fault(input logic [31:0] pc,
                                          input logic [31:0] base);
    logic [31:0] off;
    off = pc - base;
    return (pc[1:0] != 2'b00) || (pc < base) ||
           (off >= 32'(IFQ_IMEM_WORDS * 4));
  endfunction

endpackage

// File: rtl/ifq_entry_ram.sv
// ifq_entry_ram: entry storage for the IF/ID queue.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
// Contents are not reset; the queue never exposes an unwritten entry.
module ifq_entry_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction queue (DEPTH entries, power of 2).
// Ports: clk, reset (sync, active-high), flush (redirect, discards all);
//   in_valid/in_ready/in_pc/in_instr  - push side from fetch;
//   out_valid/out_ready/out_pc/out_instr - head entry to decode (zero when empty);
//   out_exc (only with IFQ_ADDR_EXC_EN) - head entry carries an AdEL fault;
//   count - occupied entries.
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_BASE = IFQ_PC_BASE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
`ifdef IFQ_ADDR_EXC_EN
  output logic                     out_exc,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("if_id_queue: DEPTH must be a power of two, at least 2");
  end
  if (PC_BASE[1:0] != 2'b00) begin : g_bad_base
    $error("if_id_queue: PC_BASE must be word aligned");
  end

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic       push, pop;
  ifq_entry_t wr_entry, rd_entry;
  logic [$bits(ifq_entry_t)-1:0] rd_bits;

  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = in_pc;
    wr_entry.instr = in_instr;
`ifdef IFQ_ADDR_EXC_EN
    wr_entry.exc   = ifq_addr_fault(in_pc, PC_BASE);
    if (wr_entry.exc) wr_entry.instr = IFQ_NOP;
`endif
  end

  ifq_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_ram (
    .clk   (clk),
    .we    (push && !flush && !reset),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_bits)
  );

  always_comb begin
    rd_entry  = ifq_entry_t'(rd_bits);
    out_pc    = out_valid ? rd_entry.pc    : '0;
    out_instr = out_valid ? rd_entry.instr : IFQ_NOP;
`ifdef IFQ_ADDR_EXC_EN
    out_exc   = out_valid ? rd_entry.exc   : 1'b0;
`endif
    count     = count_q;
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0]  count;
`ifdef IFQ_ADDR_EXC_EN
  logic        out_exc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4), .PC_BASE(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
`ifdef IFQ_ADDR_EXC_EN
    .out_exc   (out_exc),
`endif
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a push request; instruction word is ~pc so it is distinct from pc.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ~pc;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step(); step();
    reset = 1'b0;

    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // Fill to full with decode stalled.
    drive(1'b1, 32'h3000, 1'b0); step();
    check("lat1_out_pc", out_pc, 32'h3000);
    check("lat1_out_instr", out_instr, 32'hFFFF_CFFF);
    drive(1'b1, 32'h3004, 1'b0); step();
    drive(1'b1, 32'h3008, 1'b0); step();
    drive(1'b1, 32'h300C, 1'b0); step();
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h3010, 1'b0); step();
    check("drop_count", 32'(count), 32'd4);
    check("stall_head", out_pc, 32'h3000);

    // Drain in order.
    drive(1'b0, 32'h0, 1'b1);
    check("drain0", out_pc, 32'h3000);
    step(); check("drain1", out_pc, 32'h3004);
    step(); check("drain2", out_pc, 32'h3008);
    step(); check("drain3", out_pc, 32'h300C);
    step();
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_pc", out_pc, 32'h0);
    check("empty_instr", out_instr, 32'h0);
    step();
    check("pop_empty_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2.
    drive(1'b1, 32'h3000, 1'b0); step();
    drive(1'b1, 32'h3004, 1'b0); step();
    check("pp_pre_count", 32'(count), 32'd2);
    drive(1'b1, 32'h3010, 1'b1); step();
    check("pp_count", 32'(count), 32'd2);
    check("pp_head", out_pc, 32'h3004);
    drive(1'b0, 32'h0, 1'b1); step();
    check("pp_next", out_pc, 32'h3010);
    step();
    check("pp_empty", 32'(count), 32'd0);

    // Wrap-around: steady push+pop at count 1.
    drive(1'b1, 32'h3100, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h3104 + 32'(4 * i), 1'b1); step();
      check("wrap_head", out_pc, 32'h3104 + 32'(4 * i));
      check("wrap_count", 32'(count), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1); step();
    check("wrap_empty", 32'(count), 32'd0);

    // Flush at count 3 with a concurrent push and pop.
    drive(1'b1, 32'h3200, 1'b0); step();
    drive(1'b1, 32'h3204, 1'b0); step();
    drive(1'b1, 32'h3208, 1'b0); step();
    check("fl_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'h4000, 1'b1); step();
    flush = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_pc", out_pc, 32'h0);
    drive(1'b1, 32'h5000, 1'b0); step();
    check("fl_new_head", out_pc, 32'h5000);
    check("fl_new_count", 32'(count), 32'd1);

    // Full queue rejects input even when popping in the same cycle.
    drive(1'b1, 32'h5004, 1'b0); step();
    drive(1'b1, 32'h5008, 1'b0); step();
    drive(1'b1, 32'h500C, 1'b0); step();
    drive(1'b1, 32'h5010, 1'b1); step();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_head", out_pc, 32'h5004);
    drive(1'b0, 32'h0, 1'b1);
    step(); check("fullpop_d1", out_pc, 32'h5008);
    step(); check("fullpop_d2", out_pc, 32'h500C);
    step(); check("fullpop_empty", 32'(count), 32'd0);

    // Reset mid-operation, with flush and push also asserted.
    drive(1'b1, 32'h6000, 1'b0); step();
    drive(1'b1, 32'h6004, 1'b0); step();
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h6008, 1'b0); step();
    reset = 1'b0; flush = 1'b0;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h6100, 1'b0); step();
    check("mrst_head", out_pc, 32'h6100);
    check("mrst_new_count", 32'(count), 32'd1);
    drive(1'b0, 32'h0, 1'b1); step();

`ifdef IFQ_ADDR_EXC_EN
    check("exc_empty", 32'(out_exc), 32'd0);
    drive(1'b1, 32'h3002, 1'b0); step();
    check("exc_mis_flag", 32'(out_exc), 32'd1);
    check("exc_mis_instr", out_instr, 32'h0);
    drive(1'b1, 32'h7000, 1'b1); step();
    check("exc_rng_flag", 32'(out_exc), 32'd1);
    check("exc_rng_instr", out_instr, 32'h0);
    drive(1'b1, 32'h3004, 1'b1); step();
    check("exc_ok_flag", 32'(out_exc), 32'd0);
    check("exc_ok_instr", out_instr, 32'hFFFF_CFFB);
    drive(1'b0, 32'h0, 1'b1); step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
